// File: rtl/letter_scroll_ctrl.sv
// Push-button message entry and four-digit letter scroller for seven-segment letter decoders.
// Optional button debouncing is enabled by defining LETTER_SCROLL_DEBOUNCE_EN.
module letter_scroll_ctrl #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned SCROLL_DIV   = 25_000_000,
    parameter int unsigned DEBOUNCE_CNT = 50_000
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         BTN_NEXT,
    input  logic                         BTN_COMMIT,
    input  logic                         BTN_MODE,
    input  logic                         BTN_CLEAR,
    output logic [4:0]                   DIG0,
    output logic [4:0]                   DIG1,
    output logic [4:0]                   DIG2,
    output logic [4:0]                   DIG3,
    output logic [$clog2(DEPTH+1)-1:0]   LEN,
    output logic                         FULL,
    output logic                         SCROLLING
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = $clog2(DEPTH + 4) + 1;
    localparam int unsigned TW = $clog2(SCROLL_DIV);

    if (DEPTH < 4 || DEPTH > 32 || SCROLL_DIV < 2 || DEBOUNCE_CNT < 1) begin : g_param_err
        $error("letter_scroll_ctrl: parameter out of range");
    end

    typedef enum logic {EDIT, SCROLL} state_t;

    logic [3:0] btn_raw;
    logic [3:0] btn_lvl;
    assign btn_raw = {BTN_CLEAR, BTN_MODE, BTN_COMMIT, BTN_NEXT};

`ifdef LETTER_SCROLL_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    logic [3:0]    sync1_q, sync2_q, deb_q;
    logic [CW-1:0] cnt_q [4];

    // Two-flop synchronizer, then the level follows only after DEBOUNCE_CNT stable cycles
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == CW'(DEBOUNCE_CNT - 1)) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end
    assign btn_lvl = deb_q;
`else
    assign btn_lvl = btn_raw;
`endif

    state_t        state_q, state_d;
    logic [4:0]    cur_q, cur_d;
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] off_q, off_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    btn_q;
    logic          ready_q;
    logic          wr_en;
    logic [4:0]    msg_q [DEPTH];

    // ready_q masks the first cycle after reset so a held button cannot fire
    logic [3:0] ev;
    assign ev = btn_lvl & ~btn_q & {4{ready_q}};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= EDIT;
            cur_q   <= '0;
            len_q   <= '0;
            off_q   <= '0;
            tmr_q   <= '0;
            btn_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
            off_q   <= off_d;
            tmr_q   <= tmr_d;
            btn_q   <= btn_lvl;
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) msg_q[AW'(len_q)] <= cur_q;
    end

    logic [IW-1:0] period;
    assign period = IW'(len_q) + IW'(4);

    // Next-state: only the highest-priority event (CLEAR > MODE > COMMIT > NEXT) acts
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        len_d   = len_q;
        off_d   = off_q;
        tmr_d   = tmr_q;
        wr_en   = 1'b0;
        case (state_q)
            EDIT: begin
                if (ev[3]) begin
                    len_d = '0;
                    cur_d = '0;
                end else if (ev[2]) begin
                    if (len_q != '0) begin
                        state_d = SCROLL;
                        off_d   = '0;
                        tmr_d   = '0;
                    end
                end else if (ev[1]) begin
                    if (cur_q != 5'd0 && len_q < LW'(DEPTH)) begin
                        wr_en = 1'b1;
                        len_d = len_q + LW'(1);
                    end
                end else if (ev[0]) begin
                    cur_d = (cur_q == 5'd25) ? 5'd1 : cur_q + 5'd1;
                end
            end
            SCROLL: begin
                if (ev[3]) begin
                    state_d = EDIT;
                    len_d   = '0;
                    cur_d   = '0;
                end else if (ev[2]) begin
                    state_d = EDIT;
                end else if (tmr_q == TW'(SCROLL_DIV - 1)) begin
                    tmr_d = '0;
                    off_d = (off_q + IW'(1) == period) ? '0 : off_q + IW'(1);
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = EDIT;
        endcase
    end

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] k);
        logic [IW-1:0] s;
        s = off_q + k;
        if (s >= period) s = s - period;
        return s;
    endfunction

    function automatic logic [4:0] stream(input logic [IW-1:0] i);
        return (i < IW'(len_q)) ? msg_q[AW'(i)] : 5'd0;
    endfunction

    // Display: cursor plus last three letters in EDIT, sliding window over the stream in SCROLL
    always_comb begin
        DIG0 = '0;
        DIG1 = '0;
        DIG2 = '0;
        DIG3 = '0;
        if (state_q == SCROLL) begin
            DIG3 = stream(wrap(IW'(0)));
            DIG2 = stream(wrap(IW'(1)));
            DIG1 = stream(wrap(IW'(2)));
            DIG0 = stream(wrap(IW'(3)));
        end else begin
            DIG0 = cur_q;
            if (len_q >= LW'(1)) DIG1 = msg_q[AW'(len_q - LW'(1))];
            if (len_q >= LW'(2)) DIG2 = msg_q[AW'(len_q - LW'(2))];
            if (len_q >= LW'(3)) DIG3 = msg_q[AW'(len_q - LW'(3))];
        end
    end

    assign LEN       = len_q;
    assign FULL      = (len_q == LW'(DEPTH));
    assign SCROLLING = (state_q == SCROLL);

endmodule

// File: tb/tb_letter_scroll_ctrl.sv
// Directed bench for letter_scroll_ctrl with DEPTH=4, SCROLL_DIV=4.
module tb_letter_scroll_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       BTN_NEXT, BTN_COMMIT, BTN_MODE, BTN_CLEAR;
    logic [4:0] DIG0, DIG1, DIG2, DIG3;
    logic [2:0] LEN;
    logic       FULL, SCROLLING;

    int total = 0;
    int bad   = 0;

    letter_scroll_ctrl #(.DEPTH(4), .SCROLL_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .BTN_NEXT  (BTN_NEXT),
        .BTN_COMMIT(BTN_COMMIT),
        .BTN_MODE  (BTN_MODE),
        .BTN_CLEAR (BTN_CLEAR),
        .DIG0      (DIG0),
        .DIG1      (DIG1),
        .DIG2      (DIG2),
        .DIG3      (DIG3),
        .LEN       (LEN),
        .FULL      (FULL),
        .SCROLLING (SCROLLING)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a button mask {clear,mode,commit,next} across exactly one rising edge
    task automatic press(input logic [3:0] m);
        @(negedge CLOCK_50);
        {BTN_CLEAR, BTN_MODE, BTN_COMMIT, BTN_NEXT} = m;
        @(negedge CLOCK_50);
        {BTN_CLEAR, BTN_MODE, BTN_COMMIT, BTN_NEXT} = 4'b0000;
    endtask

    task automatic check_digs(input string tag, input logic [4:0] d3, input logic [4:0] d2,
                              input logic [4:0] d1, input logic [4:0] d0);
        check({tag, "_dig3"}, 32'(DIG3), 32'(d3));
        check({tag, "_dig2"}, 32'(DIG2), 32'(d2));
        check({tag, "_dig1"}, 32'(DIG1), 32'(d1));
        check({tag, "_dig0"}, 32'(DIG0), 32'(d0));
    endtask

    localparam logic [3:0] NXT = 4'b0001, COM = 4'b0010, MOD = 4'b0100, CLR = 4'b1000;

    initial begin
        RESET = 1'b1;
        {BTN_CLEAR, BTN_MODE, BTN_COMMIT, BTN_NEXT} = 4'b0000;
        #12;
        check_digs("rst", 5'd0, 5'd0, 5'd0, 5'd0);
        check("rst_len", 32'(LEN), 32'd0);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_scroll", 32'(SCROLLING), 32'd0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // 26 NEXT presses: 1..25 then wrap to 1
        for (int k = 1; k <= 26; k++) begin
            press(NXT);
            check("next_cur", 32'(DIG0), (k <= 25) ? 32'(k) : 32'd1);
        end
        check_digs("next_end", 5'd0, 5'd0, 5'd0, 5'd1);

        // Build message 3,4
        press(CLR);
        check("clr_len", 32'(LEN), 32'd0);
        check("clr_cur", 32'(DIG0), 32'd0);
        press(NXT); press(NXT); press(NXT);
        press(COM); press(NXT); press(COM);
        check("two_len", 32'(LEN), 32'd2);
        check_digs("two", 5'd0, 5'd3, 5'd4, 5'd4);

        // MODE+COMMIT together: MODE wins, no append
        press(MOD | COM);
        check("mc_scroll", 32'(SCROLLING), 32'd1);
        check("mc_len", 32'(LEN), 32'd2);
        check_digs("mc", 5'd3, 5'd4, 5'd0, 5'd0);
        press(MOD);
        check("back_scroll", 32'(SCROLLING), 32'd0);
        check("back_len", 32'(LEN), 32'd2);
        check("back_cur", 32'(DIG0), 32'd4);

        // Fill buffer with 1,2,3,4
        press(CLR);
        for (int k = 1; k <= 4; k++) begin
            press(NXT);
            press(COM);
            check("fill_len", 32'(LEN), 32'(k));
            check("fill_full", 32'(FULL), (k == 4) ? 32'd1 : 32'd0);
        end
        press(NXT);
        press(COM);
        check("over_len", 32'(LEN), 32'd4);
        check("over_full", 32'(FULL), 32'd1);
        check_digs("over", 5'd2, 5'd3, 5'd4, 5'd5);

        // Scroll: P = 8, step every 4 cycles
        press(MOD);
        check("sc_scroll", 32'(SCROLLING), 32'd1);
        check_digs("sc_off0", 5'd1, 5'd2, 5'd3, 5'd4);
        repeat (3) @(negedge CLOCK_50);
        check_digs("sc_hold", 5'd1, 5'd2, 5'd3, 5'd4);
        @(negedge CLOCK_50);
        check_digs("sc_off1", 5'd2, 5'd3, 5'd4, 5'd0);
        repeat (16) @(negedge CLOCK_50);
        check_digs("sc_off5", 5'd0, 5'd0, 5'd0, 5'd1);
        repeat (12) @(negedge CLOCK_50);
        check_digs("sc_wrap", 5'd1, 5'd2, 5'd3, 5'd4);
        check("sc_len", 32'(LEN), 32'd4);

        // Async reset mid-scroll with NEXT held across it
        @(negedge CLOCK_50);
        BTN_NEXT = 1'b1;
        #2 RESET = 1'b1;
        #1;
        check_digs("ar", 5'd0, 5'd0, 5'd0, 5'd0);
        check("ar_len", 32'(LEN), 32'd0);
        check("ar_full", 32'(FULL), 32'd0);
        check("ar_scroll", 32'(SCROLLING), 32'd0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("held_no_ev", 32'(DIG0), 32'd0);
        BTN_NEXT = 1'b0;
        press(NXT);
        check("repress", 32'(DIG0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
